// File: rtl/gate_teleporter.sv
// Teleport gate controller: arms on visible gates, jumps the frog to the
// partner gate on the frame after a collision, then locks out re-triggers.
module gate_teleporter #(
  parameter int GATE_SIZE = 32,
  parameter int COOLDOWN  = 25000000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        collision_A,
  input  logic        collision_B,
  input  logic [10:0] A_start_offsetX,
  input  logic [10:0] A_start_offsetY,
  input  logic [10:0] B_start_offsetX,
  input  logic [10:0] B_start_offsetY,
  output logic        change_coord,
  output logic        teleport,
  output logic [10:0] teleport_X,
  output logic [10:0] teleport_Y,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_WAIT_SHOW,
    S_ARMED,
    S_JUMP,
    S_REQ,
    S_WAIT_HIDE,
    S_COOL
  } state_t;

  localparam logic [25:0] CD_LOAD = 26'(COOLDOWN - 1);
  localparam logic [10:0] X_LIM   = 11'(639 - GATE_SIZE);
  localparam logic [10:0] Y_LIM   = 11'(479 - GATE_SIZE);

  state_t      state;
  state_t      nxt;
  logic [25:0] cnt;
  logic        frame_cnt;
  logic        hit_a;
  logic        hit_b;
  logic        win_a;
  logic        win_b;
  logic        nonzero;
  logic        off_screen;
  logic        visible;

  assign nonzero = |{A_start_offsetX, A_start_offsetY,
                     B_start_offsetX, B_start_offsetY};

  // A gate parked past the screen edge still counts as shown.
  assign off_screen = (A_start_offsetX > X_LIM) |
                      (B_start_offsetX > X_LIM) |
                      (A_start_offsetY > Y_LIM) |
                      (B_start_offsetY > Y_LIM);

  assign visible = nonzero | off_screen;

  // A collision on the frame-start cycle itself still counts.
  assign win_a = hit_a | collision_A;
  assign win_b = hit_b | collision_B;

  assign teleport     = (state == S_JUMP);
  assign change_coord = (state == S_REQ);
  assign busy         = (state != S_ARMED);

  // Next-state decision.
  always_comb begin
    nxt = state;
    unique case (state)
      S_WAIT_SHOW: if (visible) nxt = S_COOL;
      S_ARMED:
        if (startOfFrame && (win_a || win_b))
          nxt = S_JUMP;
      S_JUMP:      nxt = S_REQ;
      S_REQ:       nxt = S_WAIT_HIDE;
      S_WAIT_HIDE:
        if (!visible)
          nxt = S_WAIT_SHOW;
        else if (startOfFrame && frame_cnt)
          nxt = S_COOL;
      S_COOL:
        if (!visible)
          nxt = S_WAIT_SHOW;
        else if (cnt == '0)
          nxt = S_ARMED;
      default:     nxt = S_WAIT_SHOW;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= S_WAIT_SHOW;
    else       state <= nxt;
  end

  // Lockout counter, reloaded on every entry into cooldown.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (nxt == S_COOL && state != S_COOL)
      cnt <= CD_LOAD;
    else if (state == S_COOL && cnt != '0)
      cnt <= cnt - 26'd1;
  end

  // Frames seen while waiting for the gates to be hidden.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)
      frame_cnt <= 1'b0;
    else if (state != S_WAIT_HIDE)
      frame_cnt <= 1'b0;
    else if (startOfFrame)
      frame_cnt <= 1'b1;
  end

  // Per-frame collision flags, only meaningful while armed.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      hit_a <= 1'b0;
      hit_b <= 1'b0;
    end else if (state != S_ARMED || startOfFrame) begin
      hit_a <= 1'b0;
      hit_b <= 1'b0;
    end else begin
      hit_a <= win_a;
      hit_b <= win_b;
    end
  end

  // Destination is the partner gate, captured on the jump decision.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      teleport_X <= '0;
      teleport_Y <= '0;
    end else if (state == S_ARMED && nxt == S_JUMP) begin
      if (win_a) begin
        teleport_X <= B_start_offsetX;
        teleport_Y <= B_start_offsetY;
      end else begin
        teleport_X <= A_start_offsetX;
        teleport_Y <= A_start_offsetY;
      end
    end
  end

endmodule

// File: tb/tb_gate_teleporter.sv
// Bench for gate_teleporter: directed scenarios then random traffic,
// all checked against a behavioural model of the gate rules.
module tb_gate_teleporter;

  localparam int CD = 4;

  logic        CLK;
  logic        reset;
  logic        startOfFrame;
  logic        collision_A;
  logic        collision_B;
  logic [10:0] A_start_offsetX;
  logic [10:0] A_start_offsetY;
  logic [10:0] B_start_offsetX;
  logic [10:0] B_start_offsetY;
  logic        change_coord;
  logic        teleport;
  logic [10:0] teleport_X;
  logic [10:0] teleport_Y;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  gate_teleporter #(.GATE_SIZE(32), .COOLDOWN(CD)) dut (
    .CLK             (CLK),
    .reset           (reset),
    .startOfFrame    (startOfFrame),
    .collision_A     (collision_A),
    .collision_B     (collision_B),
    .A_start_offsetX (A_start_offsetX),
    .A_start_offsetY (A_start_offsetY),
    .B_start_offsetX (B_start_offsetX),
    .B_start_offsetY (B_start_offsetY),
    .change_coord    (change_coord),
    .teleport        (teleport),
    .teleport_X      (teleport_X),
    .teleport_Y      (teleport_Y),
    .busy            (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: flags for which waiting phase we are in, a remaining-lockout
  // count, and a pending pulse (1 = teleport now, 2 = coord request now).
  bit          m_armed;
  bit          m_ws;
  bit          m_wh;
  int          m_lock;
  int          m_frames;
  int          m_pulse;
  bit          m_hA;
  bit          m_hB;
  logic [10:0] m_tx;
  logic [10:0] m_ty;

  task automatic m_reset();
    m_armed  = 0;
    m_ws     = 1;
    m_wh     = 0;
    m_lock   = 0;
    m_frames = 0;
    m_pulse  = 0;
    m_hA     = 0;
    m_hB     = 0;
    m_tx     = '0;
    m_ty     = '0;
  endtask

  task automatic m_step();
    bit vis;
    bit a;
    bit b;
    vis = (A_start_offsetX != 0) || (A_start_offsetY != 0) ||
          (B_start_offsetX != 0) || (B_start_offsetY != 0);
    if (m_pulse == 1) begin
      m_pulse = 2;
    end else if (m_pulse == 2) begin
      m_pulse  = 0;
      m_wh     = 1;
      m_frames = 0;
    end else if (m_wh) begin
      if (!vis) begin
        m_wh = 0;
        m_ws = 1;
      end else if (startOfFrame) begin
        m_frames++;
        if (m_frames == 2) begin
          m_wh   = 0;
          m_lock = CD;
        end
      end
    end else if (m_ws) begin
      if (vis) begin
        m_ws   = 0;
        m_lock = CD;
      end
    end else if (m_lock > 0) begin
      if (!vis) begin
        m_lock = 0;
        m_ws   = 1;
      end else begin
        m_lock--;
        if (m_lock == 0) m_armed = 1;
      end
    end else if (m_armed) begin
      a = m_hA || collision_A;
      b = m_hB || collision_B;
      if (startOfFrame) begin
        m_hA = 0;
        m_hB = 0;
        if (a || b) begin
          m_armed = 0;
          m_pulse = 1;
          m_tx = a ? B_start_offsetX : A_start_offsetX;
          m_ty = a ? B_start_offsetY : A_start_offsetY;
        end
      end else begin
        m_hA = a;
        m_hB = b;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cmp_all();
    chk("teleport", {31'd0, teleport}, {31'd0, m_pulse == 1});
    chk("change_coord", {31'd0, change_coord}, {31'd0, m_pulse == 2});
    chk("busy", {31'd0, busy}, {31'd0, !m_armed});
    chk("teleport_X", {21'd0, teleport_X}, {21'd0, m_tx});
    chk("teleport_Y", {21'd0, teleport_Y}, {21'd0, m_ty});
  endtask

  task automatic tick();
    @(posedge CLK);
    if (reset) m_reset();
    else       m_step();
    #1;
    cmp_all();
  endtask

  task automatic set_gates(int ax, int ay, int bx, int by);
    A_start_offsetX = 11'(ax);
    A_start_offsetY = 11'(ay);
    B_start_offsetX = 11'(bx);
    B_start_offsetY = 11'(by);
  endtask

  // Collision frame followed by a frame start; ends in the jump cycle.
  task automatic jump_via(bit ca, bit cb);
    collision_A = ca;
    collision_B = cb;
    tick();
    collision_A  = 0;
    collision_B  = 0;
    startOfFrame = 1;
    tick();
    startOfFrame = 0;
  endtask

  // From the coord-request cycle: gates stay up, two frames time out.
  task automatic timeout_rearm();
    tick();
    startOfFrame = 1;
    tick();
    startOfFrame = 0;
    tick();
    startOfFrame = 1;
    tick();
    startOfFrame = 0;
    chk("to_cool_busy", {31'd0, busy}, 32'd1);
    repeat (3) tick();
    chk("to_cool_end", {31'd0, busy}, 32'd1);
    tick();
    chk("to_rearmed", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int r;
    reset        = 1;
    startOfFrame = 0;
    collision_A  = 0;
    collision_B  = 0;
    set_gates(100, 82, 500, 360);
    m_reset();
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_tele", {31'd0, teleport}, 32'd0);
    chk("rst_tx", {21'd0, teleport_X}, 32'd0);
    repeat (2) tick();
    reset = 0;

    repeat (4) tick();
    chk("cool_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("armed", {31'd0, busy}, 32'd0);

    jump_via(1, 0);
    chk("a_tele", {31'd0, teleport}, 32'd1);
    chk("a_tx", {21'd0, teleport_X}, 32'd500);
    chk("a_ty", {21'd0, teleport_Y}, 32'd360);
    tick();
    chk("a_cc", {31'd0, change_coord}, 32'd1);
    chk("a_tele_off", {31'd0, teleport}, 32'd0);
    timeout_rearm();

    jump_via(0, 1);
    chk("b_tx", {21'd0, teleport_X}, 32'd100);
    chk("b_ty", {21'd0, teleport_Y}, 32'd82);
    tick();
    timeout_rearm();

    jump_via(1, 1);
    chk("ab_tx", {21'd0, teleport_X}, 32'd500);
    chk("ab_ty", {21'd0, teleport_Y}, 32'd360);
    tick();
    chk("ab_cc", {31'd0, change_coord}, 32'd1);

    set_gates(0, 0, 0, 0);
    repeat (3) tick();
    set_gates(320, 100, 400, 380);
    tick();
    chk("show_cool", {31'd0, busy}, 32'd1);
    collision_A = 1;
    repeat (3) tick();
    collision_A = 0;
    tick();
    chk("show_armed", {31'd0, busy}, 32'd0);
    startOfFrame = 1;
    tick();
    startOfFrame = 0;
    chk("stale_hit", {31'd0, teleport}, 32'd0);
    tick();
    chk("stale_hit2", {31'd0, teleport}, 32'd0);

    jump_via(1, 0);
    chk("j_tele", {31'd0, teleport}, 32'd1);
    chk("j_tx", {21'd0, teleport_X}, 32'd400);
    reset = 1;
    #1;
    m_reset();
    chk("mid_rst_tele", {31'd0, teleport}, 32'd0);
    chk("mid_rst_tx", {21'd0, teleport_X}, 32'd0);
    chk("mid_rst_ty", {21'd0, teleport_Y}, 32'd0);
    cmp_all();
    tick();
    reset = 0;
    repeat (3) tick();

    for (int i = 0; i < 4000; i++) begin
      startOfFrame = ($urandom_range(0, 7) == 0);
      collision_A  = ($urandom_range(0, 5) == 0);
      collision_B  = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 99);
      if (r < 3)
        set_gates(0, 0, 0, 0);
      else if (r < 9)
        set_gates($urandom_range(0, 2047), $urandom_range(0, 2047),
                  $urandom_range(0, 2047), $urandom_range(0, 2047));
      if ($urandom_range(0, 399) == 0) begin
        reset = 1;
        #1;
        m_reset();
        cmp_all();
        tick();
        reset = 0;
      end else begin
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
